// File: rtl/i2s_rx.sv
// I2S receive deserializer: oversamples an asynchronous codec bit clock in the
// system clock domain and presents left/right pairs on a valid/ready interface.
module i2s_rx #(
  parameter int BITSIZE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               bclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid,
  input  logic               ready,
  output logic               overrun,
  output logic               sync_err
);

  localparam int CW = $clog2(BITSIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(BITSIZE - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_reg, ws_sync_reg, d_sync_reg;
  logic                   bclk_prev_reg;
  logic                   bclk_s, ws_s, d_s, bit_evt;

  state_t               state_reg, state_next;
  logic                 chan_reg, chan_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BITSIZE-1:0]   shift_reg, shift_next;
  logic                 ws_q_reg, ws_q_next;
  logic                 done_reg, done_next;
  logic                 done_chan_reg, done_chan_next;
  logic [BITSIZE-1:0]   done_word_reg, done_word_next;
  logic                 sync_err_pulse, change;
  logic [BITSIZE-1:0]   shifted;

  logic [BITSIZE-1:0]   hold_reg;
  logic                 left_ok_reg;
  logic [BITSIZE-1:0]   left_chan_reg, right_chan_reg;
  logic                 valid_reg, overrun_reg, sync_err_reg;
  logic                 load_pair;

  // Input synchronizers; each serial pin gets its own chain of equal depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_reg <= '0;
      ws_sync_reg   <= '0;
      d_sync_reg    <= '0;
      bclk_prev_reg <= 1'b0;
    end else begin
      bclk_sync_reg <= {bclk_sync_reg[SYNC_STAGES-2:0], bclk};
      ws_sync_reg   <= {ws_sync_reg[SYNC_STAGES-2:0], lrclk};
      d_sync_reg    <= {d_sync_reg[SYNC_STAGES-2:0], sdata};
      bclk_prev_reg <= bclk_s;
    end
  end

  assign bclk_s  = bclk_sync_reg[SYNC_STAGES-1];
  assign ws_s    = ws_sync_reg[SYNC_STAGES-1];
  assign d_s     = d_sync_reg[SYNC_STAGES-1];
  assign bit_evt = bclk_s & ~bclk_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      chan_reg      <= 1'b0;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      ws_q_reg      <= 1'b0;
      done_reg      <= 1'b0;
      done_chan_reg <= 1'b0;
      done_word_reg <= '0;
    end else begin
      state_reg     <= state_next;
      chan_reg      <= chan_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      ws_q_reg      <= ws_q_next;
      done_reg      <= done_next;
      done_chan_reg <= done_chan_next;
      done_word_reg <= done_word_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    chan_next      = chan_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    ws_q_next      = ws_q_reg;
    done_next      = 1'b0;
    done_chan_next = chan_reg;
    done_word_next = done_word_reg;
    sync_err_pulse = 1'b0;
    change         = 1'b0;
    shifted        = {shift_reg[BITSIZE-2:0], d_s};

    // ws_q keeps tracking while disabled so the first change after re-enable is real.
    if (bit_evt) begin
      ws_q_next = ws_s;
      change    = (ws_s != ws_q_reg);
    end

    if (!enable) begin
      state_next = IDLE;
    end else if (bit_evt) begin
      case (state_reg)
        IDLE: begin
          if (change && !ws_s) begin
            state_next = SHIFT;
            chan_next  = 1'b0;
            cnt_next   = '0;
          end
        end
        SHIFT: begin
          if (change) begin
            // The delay bit on the change edge is the LSB of a slot exactly BITSIZE wide.
            if (cnt_reg == LAST) begin
              done_next      = 1'b1;
              done_word_next = shifted;
            end else begin
              sync_err_pulse = 1'b1;
            end
            chan_next = ws_s;
            cnt_next  = '0;
          end else begin
            shift_next = shifted;
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
              done_next      = 1'b1;
              done_word_next = shifted;
              state_next     = WAIT;
            end
          end
        end
        WAIT: begin
          if (change) begin
            state_next = SHIFT;
            chan_next  = ws_s;
            cnt_next   = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign load_pair = enable && done_reg && done_chan_reg && left_ok_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg       <= '0;
      left_ok_reg    <= 1'b0;
      left_chan_reg  <= '0;
      right_chan_reg <= '0;
      valid_reg      <= 1'b0;
      overrun_reg    <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      if (!enable || sync_err_pulse) begin
        left_ok_reg <= 1'b0;
      end else if (done_reg && !done_chan_reg) begin
        hold_reg    <= done_word_reg;
        left_ok_reg <= 1'b1;
      end else if (load_pair) begin
        left_ok_reg <= 1'b0;
      end

      if (load_pair) begin
        left_chan_reg  <= hold_reg;
        right_chan_reg <= done_word_reg;
      end
      valid_reg <= load_pair | (valid_reg & ~ready);

      if (load_pair && valid_reg && !ready) overrun_reg <= 1'b1;
      if (sync_err_pulse) sync_err_reg <= 1'b1;
    end
  end

  assign left_chan  = left_chan_reg;
  assign right_chan = right_chan_reg;
  assign valid      = valid_reg;
  assign overrun    = overrun_reg;
  assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives an I2S stream from a vector table and
// hand-written corner sequences, scoring presented pairs against a queue.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        reset, enable, bclk, lrclk, sdata, ready;
  logic [15:0] left_chan, right_chan;
  logic        valid, overrun, sync_err;

  i2s_rx #(.BITSIZE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .left_chan(left_chan), .right_chan(right_chan),
    .valid(valid), .ready(ready), .overrun(overrun), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          slot;
    int          half;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  pair_t q[$];
  vec_t  vecs[7];
  int    n_vec = 0;
  int    n_miss = 0;
  logic  prev_bit = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted pair is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && valid && ready) begin
      check("pair_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        pair_t e;
        e = q.pop_front();
        check("left_chan", 32'(left_chan), 32'(e.l));
        check("right_chan", 32'(right_chan), 32'(e.r));
        $display("pair L=%h R=%h (want %h/%h)", left_chan, right_chan, e.l, e.r);
      end
    end
  end

  task automatic send_bit(input logic lr, input logic d, input int half);
    lrclk = lr;
    sdata = d;
    repeat (half) @(posedge clk);
    #2 bclk = 1'b1;
    repeat (half) @(posedge clk);
    #2 bclk = 1'b0;
  endtask

  // One-bit I2S delay: each bit position carries the previous position's word bit.
  task automatic send_slot(input logic lr, input logic [15:0] word, input int half,
                           input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      logic d;
      d = prev_bit;
      prev_bit = (i < 16) ? word[15-i] : 1'b0;
      send_bit(lr, d, half);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot,
                            input int half);
    send_slot(1'b0, l, half, 0, slot);
    send_slot(1'b1, r, half, 0, slot);
  endtask

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    q.push_back(p);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    prev_bit = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 32'(q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_left"}, 32'(left_chan), 32'd0);
    check({tag, "_right"}, 32'(right_chan), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_sync_err"}, 32'(sync_err), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 16'h1234, 32, 4, 16'hA5C3, 16'h1234};
    vecs[1] = '{16'hA5C3, 16'h1234, 32, 4, 16'hA5C3, 16'h1234};
    vecs[2] = '{16'h8001, 16'h7FFE, 16, 2, 16'h8001, 16'h7FFE};
    vecs[3] = '{16'h8001, 16'h7FFE, 16, 2, 16'h8001, 16'h7FFE};
    vecs[4] = '{16'hFFFF, 16'h0000, 16, 2, 16'hFFFF, 16'h0000};
    vecs[5] = '{16'h0001, 16'h8000, 32, 2, 16'h0001, 16'h8000};
    vecs[6] = '{16'h5A5A, 16'hC3C3, 20, 3, 16'h5A5A, 16'hC3C3};

    reset = 1'b1; enable = 1'b1; ready = 1'b1;
    bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    check_idle_outputs("reset");

    // Continuous stream over the table; the trailing bit completes 16-bit right slots.
    @(posedge clk); #2;
    send_slot(1'b1, 16'h0000, 4, 0, 4);
    foreach (vecs[i]) begin
      expect_pair(vecs[i].exp_l, vecs[i].exp_r);
      send_frame(vecs[i].l, vecs[i].r, vecs[i].slot, vecs[i].half);
    end
    send_slot(1'b0, 16'h0000, 2, 0, 1);
    drain("table_drain");
    check("table_overrun", 32'(overrun), 32'd0);
    check("table_sync_err", 32'(sync_err), 32'd0);

    // Consumer stalls for two frames: newest pair wins and overrun sticks.
    pulse_reset();
    ready = 1'b0;
    send_slot(1'b1, 16'h0000, 2, 0, 4);
    send_frame(16'h1111, 16'h2222, 32, 2);
    send_frame(16'h3333, 16'h4444, 32, 2);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_left", 32'(left_chan), 32'h3333);
    check("ovr_right", 32'(right_chan), 32'h4444);
    expect_pair(16'h3333, 16'h4444);
    @(posedge clk); #2 ready = 1'b1;
    @(posedge clk); #2 ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_after_ready", 32'(valid), 32'd0);
    check("ovr_queue", 32'(q.size()), 32'd0);
    ready = 1'b1;

    // Stream picked up mid right slot.
    pulse_reset();
    send_slot(1'b1, 16'hDEAD, 4, 6, 26);
    expect_pair(16'hCAFE, 16'hBEEF);
    send_frame(16'hCAFE, 16'hBEEF, 32, 4);
    send_slot(1'b0, 16'h0000, 2, 0, 1);
    drain("midright_drain");

    // Left word cut after 10 bits raises sync_err and loses that frame only.
    pulse_reset();
    send_slot(1'b1, 16'h0000, 2, 0, 4);
    expect_pair(16'h0F0F, 16'hF0F0);
    send_frame(16'h0F0F, 16'hF0F0, 32, 2);
    send_slot(1'b0, 16'h9999, 2, 0, 11);
    send_slot(1'b1, 16'h7777, 2, 0, 32);
    expect_pair(16'h1357, 16'h2468);
    send_frame(16'h1357, 16'h2468, 32, 2);
    drain("syncerr_drain");
    check("syncerr_flag", 32'(sync_err), 32'd1);
    check("syncerr_overrun", 32'(overrun), 32'd0);

    // Reset in the middle of a left word, then resume on the next left slot.
    pulse_reset();
    send_slot(1'b1, 16'h0000, 2, 0, 4);
    expect_pair(16'h4321, 16'h8765);
    send_frame(16'h4321, 16'h8765, 32, 2);
    drain("rst_first_drain");
    send_slot(1'b0, 16'hAAAA, 2, 0, 8);
    pulse_reset();
    check_idle_outputs("midword_reset");
    prev_bit = 1'b1;
    send_slot(1'b0, 16'hAAAA, 2, 8, 24);
    send_slot(1'b1, 16'h5555, 2, 0, 32);
    expect_pair(16'h6C6C, 16'h3939);
    send_frame(16'h6C6C, 16'h3939, 32, 2);
    drain("rst_resume_drain");

    // Enable dropped across one frame: split frame is never paired.
    expect_pair(16'h1010, 16'h2020);
    send_frame(16'h1010, 16'h2020, 32, 2);
    send_slot(1'b0, 16'hEEEE, 2, 0, 16);
    @(posedge clk); #2 enable = 1'b0;
    send_slot(1'b0, 16'hEEEE, 2, 16, 16);
    send_slot(1'b1, 16'hDDDD, 2, 0, 10);
    @(posedge clk); #2 enable = 1'b1;
    send_slot(1'b1, 16'hDDDD, 2, 10, 22);
    expect_pair(16'h0BAD, 16'hF00D);
    send_frame(16'h0BAD, 16'hF00D, 32, 2);
    drain("enable_drain");
    check("enable_overrun", 32'(overrun), 32'd0);
    check("enable_sync_err", 32'(sync_err), 32'd0);

    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
